fp32_accumulator: RTL

- Downstream consumer of the IEEE 754 single-precision multiplier. Sums a stream of products into an internal fp32 accumulator, e.g. for dot products in the sensor-array feature datapath.
- Uses the same start/valid/busy handshake as the multiplier. The multiplier `result` feeds `operand` and its `valid` drives `start`.
- Multi-cycle, fixed-latency, one operation in flight.

---
 rtl/fp32_pkg.sv | 32 +++
 rtl/fp_lzc28.sv | 15 +
 rtl/fp32_accumulator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and operand classification
// used by the fp32 multiplier/accumulator family.
package fp32_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned BIAS  = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_e;

   // Subnormals classify as zero: the datapath flushes them on input.
   function automatic fp_class_e fp_classify(input logic [EXP_W+MAN_W-1:0] mag);
      if (mag[EXP_W+MAN_W-1:MAN_W] == EXP_MAX)
         return (mag[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
      else if (mag[EXP_W+MAN_W-1:MAN_W] == '0)
         return FP_ZERO;
      else
         return FP_NORMAL;
   endfunction

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter for the 28-bit normalisation sum;
// an all-zero input reports 28.
module fp_lzc28 (
   input  logic [27:0] value,
   output logic [4:0]  lz
);

   always_comb begin
      lz = 5'd28;
      for (int unsigned i = 0; i < 28; i++) begin
         if (value[i]) lz = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp32_accumulator.sv
// Multi-cycle fp32 accumulator: acc + operand through ALIGN/ADD/NORM/ROUND,
// round-to-nearest-even, flush-to-zero, sticky NaN/Inf.
module fp32_accumulator
   import fp32_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      operand,
   input  logic             start,
   input  logic             clear,
   output logic [31:0]      result,
   output logic             valid,
   output logic             busy,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND
   } state_e;

   state_e state_q, state_d;

   logic [31:0] acc_q;
   logic [31:0] a_q, b_q;
   logic        clr_q;
   logic        accept;

   assign accept = (state_q == ST_IDLE) && start;
   assign result = acc_q;

   // ---------------- ALIGN ----------------
   fp_class_e   cls_a, cls_b;
   logic [30:0] mag_a, mag_b, mag_big, mag_small;
   logic        swap;
   logic [7:0]  shift;
   logic [26:0] sm_ext, sm_mask, al_small_d, al_big_d;
   logic        al_spec_d;
   logic [31:0] al_spec_val_d;

   always_comb begin
      cls_a = fp_classify(a_q[30:0]);
      cls_b = fp_classify(b_q[30:0]);
      mag_a = (cls_a == FP_ZERO) ? '0 : a_q[30:0];
      mag_b = (cls_b == FP_ZERO) ? '0 : b_q[30:0];
      swap      = mag_b > mag_a;
      mag_big   = swap ? mag_b : mag_a;
      mag_small = swap ? mag_a : mag_b;
      shift     = mag_big[30:23] - mag_small[30:23];
      al_big_d  = {mag_big[30:23] != '0, mag_big[22:0], 3'b000};
      sm_ext    = {mag_small[30:23] != '0, mag_small[22:0], 3'b000};
      sm_mask   = ~({27{1'b1}} << shift);
      if (shift >= 8'd27)
         al_small_d = {26'b0, |sm_ext};
      else
         al_small_d = (sm_ext >> shift) | {26'b0, |(sm_ext & sm_mask)};

      al_spec_d     = 1'b0;
      al_spec_val_d = QNAN;
      if (cls_a == FP_NAN || cls_b == FP_NAN ||
          (cls_a == FP_INF && cls_b == FP_INF && a_q[31] != b_q[31])) begin
         al_spec_d     = 1'b1;
         al_spec_val_d = QNAN;
      end else if (cls_a == FP_INF) begin
         al_spec_d     = 1'b1;
         al_spec_val_d = a_q[31] ? NEG_INF : POS_INF;
      end else if (cls_b == FP_INF) begin
         al_spec_d     = 1'b1;
         al_spec_val_d = b_q[31] ? NEG_INF : POS_INF;
      end
   end

   logic        al_spec, al_sign_big, al_sign_small;
   logic [31:0] al_spec_val;
   logic [7:0]  al_exp;
   logic [26:0] al_big, al_small;

   // ---------------- ADD ----------------
   logic        eff_sub;
   logic [27:0] sum_d;

   always_comb begin
      eff_sub = al_sign_big ^ al_sign_small;
      sum_d   = eff_sub ? ({1'b0, al_big} - {1'b0, al_small})
                        : ({1'b0, al_big} + {1'b0, al_small});
   end

   logic        ad_spec, ad_sign, ad_zsign;
   logic [31:0] ad_spec_val;
   logic [7:0]  ad_exp;
   logic [27:0] ad_sum;

   // ---------------- NORM ----------------
   logic [4:0]  lz, sh;
   logic [26:0] nm_man_d;
   logic [9:0]  nm_exp_d;

   fp_lzc28 u_lzc (
      .value (ad_sum),
      .lz    (lz)
   );

   always_comb begin
      sh = lz - 5'd1;
      if (ad_sum[27]) begin
         nm_man_d = {ad_sum[27:2], ad_sum[1] | ad_sum[0]};
         nm_exp_d = {2'b00, ad_exp} + 10'd1;
      end else begin
         nm_man_d = ad_sum[26:0] << sh;
         nm_exp_d = {2'b00, ad_exp} - {5'b0, sh};
      end
   end

   logic        nm_spec, nm_sign, nm_zsign, nm_zero;
   logic [31:0] nm_spec_val;
   logic [26:0] nm_man;
   logic [9:0]  nm_exp;

   // ---------------- ROUND ----------------
   logic        round_up;
   logic [24:0] man25;
   logic [9:0]  exp_r;
   logic [22:0] frac;
   logic [31:0] rnd_val;

   always_comb begin
      round_up = nm_man[2] & (nm_man[1] | nm_man[0] | nm_man[3]);
      man25    = {1'b0, nm_man[26:3]} + {24'b0, round_up};
      exp_r    = nm_exp + {9'b0, man25[24]};
      frac     = man25[24] ? man25[23:1] : man25[22:0];
      if (nm_spec)
         rnd_val = nm_spec_val;
      else if (nm_zero)
         rnd_val = {nm_zsign, 31'b0};
      else if (exp_r[9] || exp_r == '0)
         rnd_val = {nm_sign, 31'b0};
      else if (exp_r >= {2'b00, EXP_MAX})
         rnd_val = nm_sign ? NEG_INF : POS_INF;
      else
         rnd_val = {nm_sign, exp_r[7:0], frac};
   end

   // ---------------- FSM ----------------
   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_d = ST_ALIGN;
         end
         ST_ALIGN: state_d = ST_ADD;
         ST_ADD:   state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         valid   <= 1'b0;
         count   <= '0;
      end else begin
         state_q <= state_d;
         valid   <= 1'b0;
         if (state_q == ST_ROUND) begin
            acc_q <= rnd_val;
            valid <= 1'b1;
            if (clr_q)
               count <= CNT_W'(1);
            else if (count != '1)
               count <= count + 1'b1;
         end else if (state_q == ST_IDLE && clear && !start) begin
            acc_q <= '0;
            count <= '0;
         end
      end
   end

   // Pipeline data registers need no reset: the FSM gates when they matter.
   always_ff @(posedge clk) begin
      if (accept) begin
         // A zero carrying the operand's sign makes acc+operand return the
         // canonicalised operand, including -0 for a -0 operand.
         a_q   <= clear ? {operand[31], 31'b0} : acc_q;
         b_q   <= operand;
         clr_q <= clear;
      end
      al_spec       <= al_spec_d;
      al_spec_val   <= al_spec_val_d;
      al_sign_big   <= swap ? b_q[31] : a_q[31];
      al_sign_small <= swap ? a_q[31] : b_q[31];
      al_exp        <= mag_big[30:23];
      al_big        <= al_big_d;
      al_small      <= al_small_d;

      ad_spec       <= al_spec;
      ad_spec_val   <= al_spec_val;
      ad_sign       <= al_sign_big;
      ad_zsign      <= eff_sub ? 1'b0 : al_sign_big;
      ad_exp        <= al_exp;
      ad_sum        <= sum_d;

      nm_spec       <= ad_spec;
      nm_spec_val   <= ad_spec_val;
      nm_sign       <= ad_sign;
      nm_zsign      <= ad_zsign;
      nm_zero       <= (ad_sum == '0);
      nm_man        <= nm_man_d;
      nm_exp        <= nm_exp_d;
   end

endmodule
